ahb_rr_arbiter: RTL and testbench
=================================

Name: ahb_rr_arbiter

Overview:
- Round-robin AHB bus arbiter sharing one AHB slave-side bus between NUM_MASTERS masters, e.g. PicoRV AHB master, debug/DMA masters.
- Sits on the GRLIB-side bus and drives each master's HGRANTx from its BUSREQx/HLOCKx.
- Tracks the address-phase owner (HMASTER) and locked state (HMASTLOCK).
- Never re-arbitrates inside a locked sequence or inside a fixed-length burst.

Parameters:
NUM_MASTERS, 4, number of masters (2..16)
MASTER_W, 2, width of master index; equals ceil(log2(NUM_MASTERS))
DEFAULT_MASTER, 0, index granted when no master requests and at reset

Ports:
HCLK  in  1  bus clock, all state on rising edge
HRESETn  in  1  asynchronous active-low reset
HBUSREQ  in  NUM_MASTERS  per-master bus request (BUSREQx)
HLOCK  in  NUM_MASTERS  per-master lock request (HLOCKx)
HTRANS  in  2  muxed transfer type of current address-phase master (00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ)
HBURST  in  3  muxed burst type of current address-phase master
HREADY  in  1  bus ready; qualifies all arbitration and phase updates
HGRANT  out  NUM_MASTERS  one-hot grant (HGRANTx)
HMASTER  out  MASTER_W  index of master owning the address phase
HMASTLOCK  out  1  current address phase is locked

Behaviour:
- Reset (async, HRESETn low):
  - HGRANT = one-hot(DEFAULT_MASTER); HMASTER = DEFAULT_MASTER; HMASTLOCK = 0.
  - beats_left = 0; rr_ptr = DEFAULT_MASTER.
  - Reset mid-burst or mid-lock abandons that state immediately.
- HGRANT is always exactly one-hot. All state updates only on rising HCLK edges with HREADY = 1. With HREADY = 0 everything holds.
- Accepted transfer = HREADY = 1 and HTRANS is NONSEQ or SEQ.
- Burst tracker, beats_left counter (5 bits):
  - Fixed length L = 4/8/16 for HBURST WRAP4/INCR4 (010/011), WRAP8/INCR8 (100/101), WRAP16/INCR16 (110/111).
  - Accepted NONSEQ with fixed HBURST: beats_left <= L-1.
  - Accepted NONSEQ with SINGLE/INCR: beats_left <= 0.
  - Accepted SEQ with beats_left != 0: beats_left <= beats_left-1.
  - HREADY = 1 with HTRANS = IDLE: beats_left <= 0 (early termination / ERROR retraction).
  - BUSY: no change.
- hold (grant frozen at this HREADY edge) when any of:
  - HLOCK[granted index] = 1;
  - accepted NONSEQ with fixed HBURST;
  - beats_left >= 3;
  - beats_left == 2 and HTRANS != SEQ.
- Arbitration at HREADY edge when not hold:
  - Search HBUSREQ starting at (granted index + 1) mod NUM_MASTERS, wrapping. The current master is the last candidate.
  - First requester wins. If none request, grant DEFAULT_MASTER.
  - HGRANT <= one-hot(winner).
- Handover timing:
  - Grant changes at the edge accepting the second-to-last beat of a fixed burst.
  - HMASTER switches at the edge accepting the last beat.
  - The new master's NONSEQ follows with no idle cycle.
- Owner/lock tracking at each HREADY edge:
  - HMASTER <= index(HGRANT) (pre-edge value).
  - HMASTLOCK <= HLOCK[index(HGRANT)] (pre-edge value).
  - So HMASTER/HMASTLOCK lag HGRANT by one HREADY-qualified cycle.
- Locked master keeps grant while its HLOCK = 1, even if other requests are pending. Release is evaluated at the first HREADY edge with HLOCK low.
- Simultaneous requests from all masters: strict rotation, each master gets one arbitration window in turn.
- A master dropping HBUSREQ mid fixed burst keeps the grant until the burst releases.

Test Plan:
- Reset with DEFAULT_MASTER=0 -> HGRANT=0001, HMASTER=0, HMASTLOCK=0. With no requests and HREADY toggling, the state holds.
- HBUSREQ=1010, HTRANS IDLE, HREADY=1 -> grants 0010, 1000, 0010, ... on successive edges; HMASTER follows one edge later.
- Master 1 granted issues INCR4 (NONSEQ then 3 SEQ) while master 2 requests:
  - HGRANT stays 0010 through NONSEQ and first SEQ.
  - HGRANT becomes 0100 on the 2nd SEQ edge.
  - HMASTER becomes 2 on the 3rd SEQ edge.
- Same INCR4 with HREADY low for 3 cycles after the 2nd SEQ -> no change until HREADY rises.
- Master 3 with HLOCK=1, HBUSREQ=1111 for 10 cycles -> HGRANT=1000 throughout, HMASTLOCK=1 one edge after grant. After HLOCK drops, the next grant goes to master 0.
- Master 0 starts INCR8, then drives IDLE after 2 beats (ERROR) -> beats_left clears to 0, and the next HREADY edge rearbitrates to the pending master 1.

Source files
------------

// File: rtl/ahb_rr_arbiter.sv
// Purpose : round-robin AHB bus arbiter that shares one slave-side bus between NUM_MASTERS masters.
// Latency : HGRANT moves at the HREADY edge after arbitration; HMASTER/HMASTLOCK follow one HREADY edge later.
// Backpressure: HREADY low freezes grant, owner, lock and burst tracking; locks and fixed bursts block re-arbitration.
//
// Ports:
//   HCLK, HRESETn    bus clock (rising edge) and asynchronous active-low reset
//   HBUSREQ, HLOCK   per-master request and lock request
//   HTRANS, HBURST   transfer type / burst type of the current address-phase master
//   HREADY           qualifies every arbitration and phase update
//   HGRANT           one-hot grant
//   HMASTER          index of the master owning the current address phase
//   HMASTLOCK        current address phase is locked
module ahb_rr_arbiter #(
    parameter int NUM_MASTERS    = 4,
    parameter int MASTER_W       = 2,
    parameter int DEFAULT_MASTER = 0
) (
    input  logic                   HCLK,
    input  logic                   HRESETn,
    input  logic [NUM_MASTERS-1:0] HBUSREQ,
    input  logic [NUM_MASTERS-1:0] HLOCK,
    input  logic [1:0]             HTRANS,
    input  logic [2:0]             HBURST,
    input  logic                   HREADY,
    output logic [NUM_MASTERS-1:0] HGRANT,
    output logic [MASTER_W-1:0]    HMASTER,
    output logic                   HMASTLOCK
);

    localparam logic [1:0] TR_IDLE   = 2'b00;
    localparam logic [1:0] TR_NONSEQ = 2'b10;
    localparam logic [1:0] TR_SEQ    = 2'b11;

    localparam logic [MASTER_W-1:0] DEF_IDX = MASTER_W'(DEFAULT_MASTER);

    // grant_idx is both the current grant and the round-robin pointer:
    // the search always starts just after the master holding the grant.
    logic [MASTER_W-1:0] grant_idx;
    logic [4:0]          beats_left;

    logic [4:0]          burst_last;   // L-1 for fixed bursts, 0 for SINGLE/INCR
    logic                fixed_burst;
    logic                nonseq_fixed;
    logic                hold;
    logic [MASTER_W-1:0] winner;
    logic                found;
    logic [MASTER_W-1:0] cand_idx;
    int                  cand;

    // ------------------------------------------------------------------
    // Burst length decode
    // ------------------------------------------------------------------
    always_comb begin
        burst_last = 5'd0;
        case (HBURST)
            3'b010, 3'b011: burst_last = 5'd3;
            3'b100, 3'b101: burst_last = 5'd7;
            3'b110, 3'b111: burst_last = 5'd15;
            default:        burst_last = 5'd0;
        endcase
    end

    assign fixed_burst  = (burst_last != 5'd0);
    assign nonseq_fixed = HREADY && (HTRANS == TR_NONSEQ) && fixed_burst;

    // Grant is frozen while the owner locks the bus or while a fixed burst
    // still has more than two beats to go. With exactly two beats left the
    // grant may move only on an accepted SEQ: that edge accepts the
    // second-to-last beat, so the new owner takes the address phase right
    // after the last beat with no idle cycle in between.
    assign hold = HLOCK[grant_idx]
                || nonseq_fixed
                || (beats_left >= 5'd3)
                || ((beats_left == 5'd2) && (HTRANS != TR_SEQ));

    // ------------------------------------------------------------------
    // Round-robin search: start at grant_idx+1, wrap, current owner last.
    // ------------------------------------------------------------------
    always_comb begin
        winner   = DEF_IDX;
        found    = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int i = 1; i <= NUM_MASTERS; i++) begin
            cand = int'(grant_idx) + i;
            if (cand >= NUM_MASTERS) begin
                cand = cand - NUM_MASTERS;
            end
            cand_idx = MASTER_W'(cand);
            if (!found && HBUSREQ[cand_idx]) begin
                winner = cand_idx;
                found  = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // State: grant, address-phase owner/lock, burst beat counter
    // ------------------------------------------------------------------
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            grant_idx  <= DEF_IDX;
            HMASTER    <= DEF_IDX;
            HMASTLOCK  <= 1'b0;
            beats_left <= 5'd0;
        end else if (HREADY) begin
            if (!hold) begin
                grant_idx <= winner;
            end
            // Owner and lock follow the grant that was valid before this edge.
            HMASTER   <= grant_idx;
            HMASTLOCK <= HLOCK[grant_idx];

            case (HTRANS)
                TR_NONSEQ: beats_left <= burst_last;
                TR_SEQ: begin
                    if (beats_left != 5'd0) begin
                        beats_left <= beats_left - 5'd1;
                    end
                end
                // IDLE mid-burst means early termination (e.g. ERROR response)
                TR_IDLE:   beats_left <= 5'd0;
                default:   beats_left <= beats_left;   // BUSY
            endcase
        end
    end

    // Grant is stored as an index so the one-hot output can never have
    // zero or multiple bits set.
    always_comb begin
        HGRANT            = '0;
        HGRANT[grant_idx] = 1'b1;
    end

endmodule

// File: tb/tb_ahb_rr_arbiter.sv
// Purpose : self-checking bench for ahb_rr_arbiter (4 masters, default master 0).
// Latency : each vector row is driven after a rising edge and checked #1 after the next rising edge.
// Backpressure: HREADY is driven from the vector table; wait-state rows expect frozen outputs.
module tb_ahb_rr_arbiter;

    localparam logic [1:0] IDLE   = 2'b00;
    localparam logic [1:0] BUSY   = 2'b01;
    localparam logic [1:0] NONSEQ = 2'b10;
    localparam logic [1:0] SEQ    = 2'b11;

    localparam logic [2:0] SINGLE = 3'b000;
    localparam logic [2:0] INCR4  = 3'b011;
    localparam logic [2:0] WRAP8  = 3'b100;
    localparam logic [2:0] INCR8  = 3'b101;

    logic       HCLK;
    logic       HRESETn;
    logic [3:0] HBUSREQ;
    logic [3:0] HLOCK;
    logic [1:0] HTRANS;
    logic [2:0] HBURST;
    logic       HREADY;
    logic [3:0] HGRANT;
    logic [1:0] HMASTER;
    logic       HMASTLOCK;

    typedef struct {
        bit         rst;
        logic [3:0] busreq;
        logic [3:0] lock;
        logic [1:0] trans;
        logic [2:0] burst;
        logic       ready;
        logic [3:0] exp_grant;
        logic [1:0] exp_master;
        logic       exp_lock;
    } vec_t;

    typedef struct {
        int         row;
        logic [3:0] grant;
        logic [1:0] master;
        logic       lock;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   total;
    int   passed;

    ahb_rr_arbiter #(
        .NUM_MASTERS    (4),
        .MASTER_W       (2),
        .DEFAULT_MASTER (0)
    ) dut (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .HBUSREQ   (HBUSREQ),
        .HLOCK     (HLOCK),
        .HTRANS    (HTRANS),
        .HBURST    (HBURST),
        .HREADY    (HREADY),
        .HGRANT    (HGRANT),
        .HMASTER   (HMASTER),
        .HMASTLOCK (HMASTLOCK)
    );

    initial begin
        HCLK = 1'b0;
        forever #5 HCLK = ~HCLK;
    end

    function automatic void add(bit rst, logic [3:0] req, logic [3:0] lck, logic [1:0] tr,
                                logic [2:0] bu, logic rdy, logic [3:0] g, logic [1:0] m,
                                logic lk);
        vec_t v;
        v.rst = rst; v.busreq = req; v.lock = lck; v.trans = tr; v.burst = bu;
        v.ready = rdy; v.exp_grant = g; v.exp_master = m; v.exp_lock = lk;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input int row, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s row %0d: got %0h, expected %0h", name, row, act, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t e;
        total   = 0;
        passed  = 0;
        HRESETn = 1'b0;
        HBUSREQ = '0;
        HLOCK   = '0;
        HTRANS  = IDLE;
        HBURST  = SINGLE;
        HREADY  = 1'b1;

        // ---------------- reset and idle hold ----------------
        //  rst req      lock     trans   burst   rdy   grant    mst lk
        add(1, 4'b0000, 4'b0000, IDLE,   SINGLE, 1'b1, 4'b0001, 2'd0, 1'b0);
        add(0, 4'b0000, 4'b0000, IDLE,   SINGLE, 1'b1, 4'b0001, 2'd0, 1'b0);
        add(0, 4'b0000, 4'b0000, IDLE,   SINGLE, 1'b0, 4'b0001, 2'd0, 1'b0);
        add(0, 4'b0000, 4'b0000, IDLE,   SINGLE, 1'b1, 4'b0001, 2'd0, 1'b0);

        // ---------------- alternating requesters 1 and 3 ----------------
        add(0, 4'b1010, 4'b0000, IDLE,   SINGLE, 1'b1, 4'b0010, 2'd0, 1'b0);
        add(0, 4'b1010, 4'b0000, IDLE,   SINGLE, 1'b1, 4'b1000, 2'd1, 1'b0);
        add(0, 4'b1010, 4'b0000, IDLE,   SINGLE, 1'b1, 4'b0010, 2'd3, 1'b0);
        add(0, 4'b1010, 4'b0000, IDLE,   SINGLE, 1'b1, 4'b1000, 2'd1, 1'b0);
        add(0, 4'b1010, 4'b0000, IDLE,   SINGLE, 1'b0, 4'b1000, 2'd1, 1'b0);
        add(0, 4'b1010, 4'b0000, IDLE,   SINGLE, 1'b1, 4'b0010, 2'd3, 1'b0);

        // ---------------- INCR4 by master 1, master 2 pending ----------------
        add(1, 4'b0000, 4'b0000, IDLE,   SINGLE, 1'b1, 4'b0001, 2'd0, 1'b0);
        add(0, 4'b0010, 4'b0000, IDLE,   SINGLE, 1'b1, 4'b0010, 2'd0, 1'b0);
        add(0, 4'b0010, 4'b0000, IDLE,   SINGLE, 1'b1, 4'b0010, 2'd1, 1'b0);
        add(0, 4'b0110, 4'b0000, NONSEQ, INCR4,  1'b1, 4'b0010, 2'd1, 1'b0);
        add(0, 4'b0110, 4'b0000, SEQ,    INCR4,  1'b1, 4'b0010, 2'd1, 1'b0);
        add(0, 4'b0110, 4'b0000, SEQ,    INCR4,  1'b1, 4'b0100, 2'd1, 1'b0);
        add(0, 4'b0100, 4'b0000, SEQ,    INCR4,  1'b1, 4'b0100, 2'd2, 1'b0);
        add(0, 4'b0100, 4'b0000, NONSEQ, SINGLE, 1'b1, 4'b0100, 2'd2, 1'b0);

        // ---------------- same INCR4 with 3 wait states after 2nd SEQ ----------------
        add(1, 4'b0000, 4'b0000, IDLE,   SINGLE, 1'b1, 4'b0001, 2'd0, 1'b0);
        add(0, 4'b0010, 4'b0000, IDLE,   SINGLE, 1'b1, 4'b0010, 2'd0, 1'b0);
        add(0, 4'b0010, 4'b0000, IDLE,   SINGLE, 1'b1, 4'b0010, 2'd1, 1'b0);
        add(0, 4'b0110, 4'b0000, NONSEQ, INCR4,  1'b1, 4'b0010, 2'd1, 1'b0);
        add(0, 4'b0110, 4'b0000, SEQ,    INCR4,  1'b1, 4'b0010, 2'd1, 1'b0);
        add(0, 4'b0110, 4'b0000, SEQ,    INCR4,  1'b1, 4'b0100, 2'd1, 1'b0);
        add(0, 4'b1111, 4'b0000, SEQ,    INCR4,  1'b0, 4'b0100, 2'd1, 1'b0);
        add(0, 4'b1111, 4'b0000, SEQ,    INCR4,  1'b0, 4'b0100, 2'd1, 1'b0);
        add(0, 4'b1111, 4'b0000, SEQ,    INCR4,  1'b0, 4'b0100, 2'd1, 1'b0);
        add(0, 4'b0100, 4'b0000, SEQ,    INCR4,  1'b1, 4'b0100, 2'd2, 1'b0);

        // ---------------- locked master 3 against all requesters ----------------
        add(1, 4'b0000, 4'b0000, IDLE,   SINGLE, 1'b1, 4'b0001, 2'd0, 1'b0);
        add(0, 4'b1000, 4'b1000, IDLE,   SINGLE, 1'b1, 4'b1000, 2'd0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            add(0, 4'b1111, 4'b1000, IDLE, SINGLE, 1'b1, 4'b1000, 2'd3, 1'b1);
        end
        add(0, 4'b1111, 4'b0000, IDLE,   SINGLE, 1'b1, 4'b0001, 2'd3, 1'b0);
        add(0, 4'b1111, 4'b0000, IDLE,   SINGLE, 1'b1, 4'b0010, 2'd0, 1'b0);

        // ---------------- INCR8 terminated early by IDLE ----------------
        add(1, 4'b0000, 4'b0000, IDLE,   SINGLE, 1'b1, 4'b0001, 2'd0, 1'b0);
        add(0, 4'b0011, 4'b0000, NONSEQ, INCR8,  1'b1, 4'b0001, 2'd0, 1'b0);
        add(0, 4'b0011, 4'b0000, SEQ,    INCR8,  1'b1, 4'b0001, 2'd0, 1'b0);
        add(0, 4'b0011, 4'b0000, IDLE,   INCR8,  1'b1, 4'b0001, 2'd0, 1'b0);
        add(0, 4'b0011, 4'b0000, IDLE,   SINGLE, 1'b1, 4'b0010, 2'd0, 1'b0);
        add(0, 4'b0011, 4'b0000, IDLE,   SINGLE, 1'b1, 4'b0001, 2'd1, 1'b0);

        // ---------------- all masters requesting: strict rotation ----------------
        add(1, 4'b0000, 4'b0000, IDLE,   SINGLE, 1'b1, 4'b0001, 2'd0, 1'b0);
        add(0, 4'b1111, 4'b0000, IDLE,   SINGLE, 1'b1, 4'b0010, 2'd0, 1'b0);
        add(0, 4'b1111, 4'b0000, IDLE,   SINGLE, 1'b1, 4'b0100, 2'd1, 1'b0);
        add(0, 4'b1111, 4'b0000, IDLE,   SINGLE, 1'b1, 4'b1000, 2'd2, 1'b0);
        add(0, 4'b1111, 4'b0000, IDLE,   SINGLE, 1'b1, 4'b0001, 2'd3, 1'b0);

        // ---------------- WRAP8 with a BUSY beat; master 0 drops request mid-burst ----------------
        add(1, 4'b0000, 4'b0000, IDLE,   SINGLE, 1'b1, 4'b0001, 2'd0, 1'b0);
        add(0, 4'b0011, 4'b0000, NONSEQ, WRAP8,  1'b1, 4'b0001, 2'd0, 1'b0);
        add(0, 4'b0011, 4'b0000, SEQ,    WRAP8,  1'b1, 4'b0001, 2'd0, 1'b0);
        add(0, 4'b0011, 4'b0000, BUSY,   WRAP8,  1'b1, 4'b0001, 2'd0, 1'b0);
        add(0, 4'b0010, 4'b0000, SEQ,    WRAP8,  1'b1, 4'b0001, 2'd0, 1'b0);
        add(0, 4'b0010, 4'b0000, SEQ,    WRAP8,  1'b1, 4'b0001, 2'd0, 1'b0);
        add(0, 4'b0010, 4'b0000, SEQ,    WRAP8,  1'b1, 4'b0001, 2'd0, 1'b0);
        add(0, 4'b0010, 4'b0000, SEQ,    WRAP8,  1'b1, 4'b0001, 2'd0, 1'b0);
        add(0, 4'b0010, 4'b0000, SEQ,    WRAP8,  1'b1, 4'b0010, 2'd0, 1'b0);
        add(0, 4'b0010, 4'b0000, SEQ,    WRAP8,  1'b1, 4'b0010, 2'd1, 1'b0);

        // Async reset must take effect before any clock edge.
        #3;
        chk("async_rst_grant", -1, 32'(HGRANT), 32'h1);
        chk("async_rst_master", -1, 32'(HMASTER), 32'h0);
        chk("async_rst_lock", -1, 32'(HMASTLOCK), 32'h0);

        @(posedge HCLK);
        #1;
        foreach (vecs[r]) begin
            HRESETn = vecs[r].rst ? 1'b0 : 1'b1;
            HBUSREQ = vecs[r].busreq;
            HLOCK   = vecs[r].lock;
            HTRANS  = vecs[r].trans;
            HBURST  = vecs[r].burst;
            HREADY  = vecs[r].ready;
            e.row    = r;
            e.grant  = vecs[r].exp_grant;
            e.master = vecs[r].exp_master;
            e.lock   = vecs[r].exp_lock;
            sb.push_back(e);

            @(posedge HCLK);
            #1;
            if (sb.size() == 0) begin
                chk("scoreboard_empty", r, 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("grant", e.row, 32'(HGRANT), 32'(e.grant));
                chk("master", e.row, 32'(HMASTER), 32'(e.master));
                chk("mastlock", e.row, 32'(HMASTLOCK), 32'(e.lock));
            end
        end

        // Reset asserted in the middle of a locked, fixed-length burst.
        HRESETn = 1'b1;
        HBUSREQ = 4'b0100;
        HLOCK   = 4'b0100;
        HTRANS  = IDLE;
        HBURST  = SINGLE;
        HREADY  = 1'b1;
        @(posedge HCLK);
        #1;
        chk("lock_seq_grant", 100, 32'(HGRANT), 32'h4);
        HBUSREQ = 4'b1111;
        HTRANS  = NONSEQ;
        HBURST  = INCR8;
        @(posedge HCLK);
        #1;
        chk("lock_seq_mastlock", 101, 32'(HMASTLOCK), 32'h1);
        HRESETn = 1'b0;
        #1;
        chk("midburst_rst_grant", 102, 32'(HGRANT), 32'h1);
        chk("midburst_rst_master", 102, 32'(HMASTER), 32'h0);
        chk("midburst_rst_lock", 102, 32'(HMASTLOCK), 32'h0);
        // After release no burst or lock may survive: master 1 wins at once.
        HLOCK   = 4'b0000;
        HBUSREQ = 4'b0010;
        HTRANS  = IDLE;
        HBURST  = SINGLE;
        @(negedge HCLK);
        HRESETn = 1'b1;
        @(posedge HCLK);
        #1;
        chk("post_rst_grant", 103, 32'(HGRANT), 32'h2);

        if (sb.size() != 0) begin
            chk("scoreboard_leftover", 0, 32'(sb.size()), 32'd0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
